// File: rtl/muldiv_unit_if.sv
// ----------------------------------------------------------------------------
// muldiv_unit_if
// Bundle between the execute stage and the multiply/divide unit.
//   start      : operation strobe, sampled on the rising clock edge
//   muldiv_op  : 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU,
//                101 MTHI, 110 MTLO, 111 reserved
//   a, b       : rs / rt operands
//   flush      : pipeline flush, aborts any in-flight operation
//   busy       : stall request back to the pipeline registers
//   done       : one-cycle completion pulse
//   hi, lo     : architectural HI/LO registers
// master = execute stage, slave = muldiv_unit.
// ----------------------------------------------------------------------------
interface muldiv_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       muldiv_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, muldiv_op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, muldiv_op, a, b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
// Iterative MIPS-style multiply/divide unit with HI/LO registers.
// Multiplies use radix-2 shift-add, divides use restoring shift-subtract,
// both on operand magnitudes in a 2*WIDTH accumulator, one bit per cycle.
// Signs are re-applied in a final FIX state that also writes HI/LO.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_unit_if.slave (start/op/operands/flush in,
//           busy/done/hi/lo out)
// Timing: start sampled at edge 0, busy for the next 33 cycles
// (32 CALC + 1 FIX), HI/LO and a done pulse appear right after the FIX edge.
// ----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   opb_reg;        // |B|: multiplicand or divisor
    logic [CNT_W-1:0]   cnt_reg;
    logic               is_div_reg;
    logic               neg_a_reg;
    logic               neg_b_reg;
    logic               div_zero_reg;

    // ------------------------------------------------------------------
    // Operand decode and magnitudes
    // ------------------------------------------------------------------
    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
        op_signed = (bus.muldiv_op == OP_MULT) || (bus.muldiv_op == OP_DIV);
        a_neg     = op_signed & bus.a[WIDTH-1];
        b_neg     = op_signed & bus.b[WIDTH-1];
        a_mag     = a_neg ? (~bus.a + 1'b1) : bus.a;
        b_mag     = b_neg ? (~bus.b + 1'b1) : bus.b;
    end

    // ------------------------------------------------------------------
    // One iteration of each algorithm
    // ------------------------------------------------------------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_upper;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        // Multiply: acc = {partial product, remaining multiplier bits}.
        // The carry out of the add becomes the new top bit after the shift.
        mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                 + (acc_reg[0] ? {1'b0, opb_reg} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

        // Divide: acc = {partial remainder, dividend/quotient bits}.
        // The shifted remainder needs WIDTH+1 bits; a set top bit of the
        // difference means the trial subtract went negative (restore).
        div_upper = acc_reg[2*WIDTH-1:WIDTH-1];
        div_diff  = div_upper - {1'b0, opb_reg};
        if (!div_diff[WIDTH]) begin
            div_next = {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {acc_reg[2*WIDTH-2:0], 1'b0};
        end
    end

    // ------------------------------------------------------------------
    // Sign correction applied in FIX
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               neg_res;

    always_comb begin
        neg_res  = neg_a_reg ^ neg_b_reg;
        prod_fix = neg_res ? (~acc_reg + 1'b1) : acc_reg;
        // With a zero divisor every trial subtract succeeds and the
        // remainder ends up as |A|; restoring A's sign gives A back, so
        // only the quotient needs forcing to all ones.
        if (div_zero_reg) begin
            quot_fix = {WIDTH{1'b1}};
        end else begin
            quot_fix = neg_res ? (~acc_reg[WIDTH-1:0] + 1'b1)
                               : acc_reg[WIDTH-1:0];
        end
        rem_fix = neg_a_reg ? (~acc_reg[2*WIDTH-1:WIDTH] + 1'b1)
                            : acc_reg[2*WIDTH-1:WIDTH];
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            acc_reg      <= '0;
            opb_reg      <= '0;
            cnt_reg      <= '0;
            is_div_reg   <= 1'b0;
            neg_a_reg    <= 1'b0;
            neg_b_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (bus.flush) begin
                // Flush wins over start and over any in-flight work.
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (bus.start) begin
                            case (bus.muldiv_op)
                                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                    acc_reg      <= {{WIDTH{1'b0}}, a_mag};
                                    opb_reg      <= b_mag;
                                    neg_a_reg    <= a_neg;
                                    neg_b_reg    <= b_neg;
                                    is_div_reg   <= (bus.muldiv_op == OP_DIV) ||
                                                    (bus.muldiv_op == OP_DIVU);
                                    div_zero_reg <= (bus.b == '0);
                                    cnt_reg      <= '0;
                                    busy_reg     <= 1'b1;
                                    state_reg    <= CALC;
                                end
                                OP_MTHI: hi_reg <= bus.a;
                                OP_MTLO: lo_reg <= bus.a;
                                default: ;
                            endcase
                        end
                    end
                    CALC: begin
                        acc_reg <= is_div_reg ? div_next : mul_next;
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == LAST_ITER) begin
                            state_reg <= FIX;
                        end
                    end
                    FIX: begin
                        if (is_div_reg) begin
                            hi_reg <= rem_fix;
                            lo_reg <= quot_fix;
                        end else begin
                            hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_reg <= prod_fix[WIDTH-1:0];
                        end
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                    default: begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed-vector bench for muldiv_unit. Inputs change on the falling edge,
// outputs are sampled on the falling edge; every expected value is a
// hand-computed constant. One line per operation plus one summary line.
// ----------------------------------------------------------------------------
module tb_muldiv_unit;
    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;

    logic clk;
    logic rst_n;
    int   check_cnt;
    int   pass_cnt;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one arithmetic op at the current falling edge, count busy cycles,
    // then check the done pulse and HI/LO. intrude_cycle != 0 drives a second
    // Start (MULT 6*7) during that busy cycle, which must be ignored.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int intrude_cycle);
        int n;
        bus.start     = 1'b1;
        bus.muldiv_op = op;
        bus.a         = a;
        bus.b         = b;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            if (intrude_cycle == n + 1) begin
                bus.start     = 1'b1;
                bus.muldiv_op = OP_MULT;
                bus.a         = 32'd6;
                bus.b         = 32'd7;
            end else begin
                bus.start = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check({tag, " busy_cycles"}, n, 32'd33);
        check({tag, " done"}, {31'd0, bus.done}, 32'd1);
        check({tag, " hi"}, bus.hi, exp_hi);
        check({tag, " lo"}, bus.lo, exp_lo);
        $display("op %s a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d", tag, a, b, bus.hi, bus.lo, n);
        @(negedge clk);
        check({tag, " done_pulse_end"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        logic saw_done;
        check_cnt     = 0;
        pass_cnt      = 0;
        rst_n         = 1'b1;
        bus.start     = 1'b0;
        bus.muldiv_op = OP_NONE;
        bus.a         = '0;
        bus.b         = '0;
        bus.flush     = 1'b0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        $display("reset asserted: busy=%b done=%b hi=%h lo=%h", bus.busy, bus.done, bus.hi, bus.lo);

        // Release and start on the very first rising edge
        @(negedge clk);
        rst_n = 1'b1;
        run_op("MULT -3*5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
        run_op("MULTU max*max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        repeat (3) @(negedge clk);
        check("MFHI readback", bus.hi, 32'hFFFF_FFFE);
        $display("mfhi readback hi=%h", bus.hi);

        run_op("MULT minint^2", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
        run_op("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("DIVU 100/0", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 0);
        run_op("DIV -7/0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 0);
        run_op("DIV minint/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
        run_op("DIV 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0);

        // Second Start during busy is ignored
        run_op("DIVU 100/7 +MULT@5", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 5);

        // MTLO / MTHI: immediate write, never busy, no done
        bus.start = 1'b1; bus.muldiv_op = OP_MTLO; bus.a = 32'h1234_5678;
        @(negedge clk);
        bus.start = 1'b0;
        check("MTLO lo", bus.lo, 32'h1234_5678);
        check("MTLO busy", {31'd0, bus.busy}, 32'd0);
        check("MTLO done", {31'd0, bus.done}, 32'd0);
        $display("op MTLO a=%h -> lo=%h busy=%b", bus.a, bus.lo, bus.busy);
        bus.start = 1'b1; bus.muldiv_op = OP_MTHI; bus.a = 32'hCAFE_F00D;
        @(negedge clk);
        bus.start = 1'b0;
        check("MTHI hi", bus.hi, 32'hCAFE_F00D);
        check("MTHI busy", {31'd0, bus.busy}, 32'd0);
        $display("op MTHI a=%h -> hi=%h busy=%b", bus.a, bus.hi, bus.busy);

        // Reserved and no-op codes are ignored
        bus.start = 1'b1; bus.muldiv_op = OP_RSVD; bus.a = 32'h5555_5555;
        @(negedge clk);
        bus.muldiv_op = OP_NONE;
        @(negedge clk);
        bus.start = 1'b0;
        check("RSVD busy", {31'd0, bus.busy}, 32'd0);
        check("RSVD hi", bus.hi, 32'hCAFE_F00D);
        check("RSVD lo", bus.lo, 32'h1234_5678);
        $display("op RSVD/NONE ignored: hi=%h lo=%h", bus.hi, bus.lo);

        // Flush in cycle 10 of a MULT
        bus.start = 1'b1; bus.muldiv_op = OP_MULT; bus.a = 32'd3; bus.b = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        check("FLUSH busy cycle1", {31'd0, bus.busy}, 32'd1);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("FLUSH busy cycle11", {31'd0, bus.busy}, 32'd0);
        check("FLUSH lo kept", bus.lo, 32'h1234_5678);
        check("FLUSH hi kept", bus.hi, 32'hCAFE_F00D);
        saw_done = 1'b0;
        repeat (40) begin
            if (bus.done !== 1'b0) saw_done = 1'b1;
            @(negedge clk);
        end
        check("FLUSH no done", {31'd0, saw_done}, 32'd0);
        check("FLUSH lo later", bus.lo, 32'h1234_5678);
        $display("op MULT flushed at cycle 10: busy=%b lo=%h", bus.busy, bus.lo);

        // Flush together with Start in IDLE discards the Start
        bus.start = 1'b1; bus.flush = 1'b1; bus.muldiv_op = OP_MTHI; bus.a = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.muldiv_op = OP_MULT; bus.a = 32'd9; bus.b = 32'd9;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        check("FLUSH+MTHI hi", bus.hi, 32'hCAFE_F00D);
        check("FLUSH+MULT busy", {31'd0, bus.busy}, 32'd0);
        $display("start with flush discarded: hi=%h busy=%b", bus.hi, bus.busy);

        // Asynchronous reset in cycle 20 of a MULT
        bus.start = 1'b1; bus.muldiv_op = OP_MULT; bus.a = 32'h0000_1234; bus.b = 32'h0000_5678;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        check("RST pre busy", {31'd0, bus.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("RST busy", {31'd0, bus.busy}, 32'd0);
        check("RST done", {31'd0, bus.done}, 32'd0);
        check("RST hi", bus.hi, 32'd0);
        check("RST lo", bus.lo, 32'd0);
        $display("async reset mid-MULT: busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("MULT 6*7 after reset", OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "timeout");
    end
endmodule
